// File: rtl/memory_controller_pkg.sv
`default_nettype none
// ============================================================================
// memory_controller_pkg : access-type field layout, size codes, FSM encoding
// Revision 1.0
// ============================================================================
package memory_controller_pkg;

    localparam int LSB_TYPE_WIDTH = 4;

    localparam int TYPE_SIZE_LSB = 0;
    localparam int TYPE_SIZE_MSB = 1;
    localparam int TYPE_UNSIGNED = 2;
    localparam int TYPE_STORE    = 3;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Instruction fetch is always an unsigned word load.
    localparam logic [LSB_TYPE_WIDTH-1:0] FETCH_TYPE = {1'b0, 1'b1, SIZE_WORD};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } mc_state_t;

    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        logic [2:0] len;
        case (size)
            SIZE_BYTE: len = 3'd1;
            SIZE_HALF: len = 3'd2;
            default:   len = 3'd4;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_controller_load_extend.sv
`default_nettype none
// ============================================================================
// load_extend : sign/zero extension of assembled load data by access size
// Revision 1.0
// ============================================================================
module load_extend
    import memory_controller_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic w_sign;

    always_comb begin
        w_sign = 1'b0;
        data   = raw;
        case (size)
            SIZE_BYTE: begin
                w_sign = raw[7] & ~is_unsigned;
                data   = {{24{w_sign}}, raw[7:0]};
            end
            SIZE_HALF: begin
                w_sign = raw[15] & ~is_unsigned;
                data   = {{16{w_sign}}, raw[15:0]};
            end
            default: data = raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/memory_controller.sv
`default_nettype none
// ============================================================================
// memory_controller : arbitrates fetch/LSB requests onto a byte-serial RAM bus
// Optional IO write stall: define MC_IO_STALL_EN.              Revision 1.0
// ============================================================================
module memory_controller
    import memory_controller_pkg::*;
#(
    parameter logic [1:0] IO_BASE_HI = 2'b11
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      flush,
    input  logic [7:0]                mem_din,
    output logic [7:0]                mem_dout,
    output logic [31:0]               mem_a,
    output logic                      mem_wr,
    input  logic                      io_buffer_full,
    input  logic                      if_en,
    input  logic [31:0]               if_addr,
    output logic                      if_rdy,
    output logic [31:0]               if_data,
    input  logic                      mc_en,
    input  logic [31:0]               mc_addr,
    input  logic [LSB_TYPE_WIDTH-1:0] mc_type,
    input  logic [31:0]               mc_write_data,
    output logic                      mc_rdy,
    output logic [31:0]               mc_read_data
);

    mc_state_t                 r_state;
    mc_state_t                 w_state_nxt;

    logic                      r_is_lsb;
    logic [31:0]               r_addr;
    logic [LSB_TYPE_WIDTH-1:0] r_type;
    logic [31:0]               r_wdata;
    logic [2:0]                r_len;
    logic [2:0]                r_step;
    logic [31:0]               r_rbuf;
    logic                      r_wr_done;

    logic [7:0]                r_mem_dout;
    logic [31:0]               r_mem_a;
    logic                      r_mem_wr;
    logic                      r_if_rdy;
    logic [31:0]               r_if_data;
    logic                      r_mc_rdy;
    logic [31:0]               r_mc_read_data;

    logic                      w_accept_lsb;
    logic                      w_accept_if;
    logic                      w_last_read;
    logic                      w_write_end;
    logic [31:0]               w_req_addr;
    logic [LSB_TYPE_WIDTH-1:0] w_req_type;
    logic                      w_wr_cur;
    logic [1:0]                w_wbyte_idx;
    logic [31:0]               w_waddr;
    logic [7:0]                w_wbyte;
    logic [1:0]                w_cap_idx;
    logic [31:0]               w_raw;
    logic [31:0]               w_rd_next_addr;
    logic [31:0]               w_ext;
    logic                      w_stall_first;
    logic                      w_stall_next;

    assign mem_dout     = r_mem_dout;
    assign mem_a        = r_mem_a;
    assign mem_wr       = r_mem_wr;
    assign if_rdy       = r_if_rdy;
    assign if_data      = r_if_data;
    assign mc_rdy       = r_mc_rdy;
    assign mc_read_data = r_mc_read_data;

    assign w_req_addr = w_accept_lsb ? mc_addr : if_addr;
    assign w_req_type = w_accept_lsb ? mc_type : FETCH_TYPE;

    // A write step is complete once its byte was actually driven with mem_wr=1;
    // a stalled or frozen step is retried with the same byte.
    always_comb begin
        w_wr_cur       = r_wr_done | r_mem_wr;
        w_wbyte_idx    = w_wr_cur ? r_step[1:0] : (r_step[1:0] - 2'd1);
        w_waddr        = r_addr + {30'd0, w_wbyte_idx};
        w_wbyte        = r_wdata[{w_wbyte_idx, 3'b000} +: 8];
        w_cap_idx      = r_step[1:0] - 2'd2;
        w_raw          = r_rbuf;
        w_raw[{w_cap_idx, 3'b000} +: 8] = mem_din;
        w_rd_next_addr = r_addr + {29'd0, r_step};
    end

`ifdef MC_IO_STALL_EN
    assign w_stall_first = io_buffer_full && (mc_addr[17:16] == IO_BASE_HI);
    assign w_stall_next  = io_buffer_full && (w_waddr[17:16] == IO_BASE_HI);
`else
    logic w_unused_io;
    assign w_unused_io   = ^{io_buffer_full, IO_BASE_HI};
    assign w_stall_first = 1'b0;
    assign w_stall_next  = 1'b0;
`endif

    load_extend u_load_extend (
        .raw         (w_raw),
        .size        (r_type[TYPE_SIZE_MSB:TYPE_SIZE_LSB]),
        .is_unsigned (r_type[TYPE_UNSIGNED]),
        .data        (w_ext)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept_lsb = 1'b0;
        w_accept_if  = 1'b0;
        w_last_read  = 1'b0;
        w_write_end  = 1'b0;
        if (rdy_in) begin
            case (r_state)
                ST_IDLE: begin
                    // Flush blocks new loads/fetches but a store may still start.
                    if (mc_en && (mc_type[TYPE_STORE] || !flush)) begin
                        w_accept_lsb = 1'b1;
                        w_state_nxt  = mc_type[TYPE_STORE] ? ST_WRITE : ST_READ;
                    end else if (if_en && !mc_en && !flush) begin
                        w_accept_if = 1'b1;
                        w_state_nxt = ST_READ;
                    end
                end
                ST_READ: begin
                    if (flush) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_step == r_len + 3'd1) begin
                        w_last_read = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_WRITE: begin
                    if (w_wr_cur && (r_step == r_len)) begin
                        w_write_end = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_is_lsb       <= 1'b0;
            r_addr         <= 32'd0;
            r_type         <= '0;
            r_wdata        <= 32'd0;
            r_len          <= 3'd0;
            r_step         <= 3'd0;
            r_rbuf         <= 32'd0;
            r_wr_done      <= 1'b0;
            r_mem_dout     <= 8'd0;
            r_mem_a        <= 32'd0;
            r_mem_wr       <= 1'b0;
            r_if_rdy       <= 1'b0;
            r_if_data      <= 32'd0;
            r_mc_rdy       <= 1'b0;
            r_mc_read_data <= 32'd0;
        end else if (!rdy_in) begin
            r_mem_wr <= 1'b0;
            if (r_state == ST_WRITE) begin
                r_wr_done <= w_wr_cur;
            end
        end else begin
            r_if_rdy <= 1'b0;
            r_mc_rdy <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_mem_wr <= 1'b0;
                    if (w_accept_lsb || w_accept_if) begin
                        r_is_lsb  <= w_accept_lsb;
                        r_addr    <= w_req_addr;
                        r_type    <= w_req_type;
                        r_wdata   <= mc_write_data;
                        r_len     <= size_to_len(w_req_type[TYPE_SIZE_MSB:TYPE_SIZE_LSB]);
                        r_step    <= 3'd1;
                        r_rbuf    <= 32'd0;
                        r_wr_done <= 1'b0;
                        r_mem_a   <= w_req_addr;
                        if (w_accept_lsb && mc_type[TYPE_STORE]) begin
                            r_mem_dout <= mc_write_data[7:0];
                            r_mem_wr   <= !w_stall_first;
                        end
                    end
                end
                ST_READ: begin
                    if (!flush) begin
                        if (r_step >= 3'd2) begin
                            r_rbuf <= w_raw;
                        end
                        if (r_step < r_len) begin
                            r_mem_a <= w_rd_next_addr;
                        end
                        r_step <= r_step + 3'd1;
                        if (w_last_read) begin
                            if (r_is_lsb) begin
                                r_mc_rdy       <= 1'b1;
                                r_mc_read_data <= w_ext;
                            end else begin
                                r_if_rdy  <= 1'b1;
                                r_if_data <= w_ext;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_write_end) begin
                        r_mem_wr <= 1'b0;
                        r_mc_rdy <= 1'b1;
                    end else begin
                        r_mem_a    <= w_waddr;
                        r_mem_dout <= w_wbyte;
                        r_mem_wr   <= !w_stall_next;
                        r_step     <= {1'b0, w_wbyte_idx} + 3'd1;
                        r_wr_done  <= 1'b0;
                    end
                end
                default: r_mem_wr <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/memory_controller.md
# memory_controller

Byte-serial memory controller between the core's two memory clients and the single-port 8-bit RAM/IO bus. The instruction fetch unit and the load/store buffer each present 32-bit requests here. The controller arbitrates between them, splits each request into sequential little-endian byte accesses, and returns assembled, extended read data with a one-cycle ready pulse. It sits directly downstream of the load/store buffer's `mc_*` port.

## Interface
Parameters:
- `IO_BASE_HI`, default `2'b11`: value of `addr[17:16]` that marks the IO region.

Ports:
- `clk_in`  in  1  system clock; all logic on the rising edge.
- `rst_in`  in  1  synchronous reset, active-low.
- `rdy_in`  in  1  global enable; low freezes all state.
- `flush`  in  1  pipeline flush.
- `mem_din`  in  8  RAM read byte; valid the cycle after its address.
- `mem_dout`  out  8  RAM write byte.
- `mem_a`  out  32  RAM byte address.
- `mem_wr`  out  1  write strobe; 1 = write.
- `io_buffer_full`  in  1  IO output FIFO full.
- `if_en`  in  1  fetch request; level, held until `if_rdy`.
- `if_addr`  in  32  fetch address.
- `if_rdy`  out  1  fetch complete, 1-cycle pulse.
- `if_data`  out  32  instruction word.
- `mc_en`  in  1  LSB request; level, held until `mc_rdy`.
- `mc_addr`  in  32  LSB address.
- `mc_type`  in  `LSB_TYPE_WIDTH`  access type.
- `mc_write_data`  in  32  store data; low bytes used.
- `mc_rdy`  out  1  LSB complete, 1-cycle pulse.
- `mc_read_data`  out  32  extended load data.

## Operation
- `mc_type` encoding, with `LSB_TYPE_WIDTH` = 4:
  - `[1:0]` size: 0 = byte, 1 = half, 2 = word.
  - `[2]` unsigned load.
  - `[3]` store.
- FSM states are IDLE, READ, WRITE and DONE.
- IDLE accepts a request on an edge with `rdy_in` = 1.
  - LSB has priority over fetch when both are asserted.
  - The controller latches the client, address, type, data and n, where n = 1, 2 or 4.
  - Fetch is always n = 4 unsigned.
- READ: in step cycle i = 1..n, drive `mem_a` = addr+i−1 with `mem_wr` = 0.
  - Byte i−1 arrives on `mem_din` in cycle i+1 and is captured at the end of that cycle.
  - After the last capture, go to DONE.
- WRITE: in step cycle i = 1..n, drive `mem_a` = addr+i−1, `mem_dout` = `write_data[8i−1:8i−8]` and `mem_wr` = 1. Then go to DONE.
- DONE lasts one cycle and pulses the selected client's `rdy`. Data outputs are valid in the same cycle. The next state is IDLE.
  - No request is accepted in DONE, so a client still holding `en` is not re-accepted.
- Load extension: bytes and halfwords are sign- or zero-extended per `type[2]`. Words pass unchanged.
- Address arithmetic is 32-bit modulo; a wrap from 0xFFFFFFFF to 0 is legal. There is no alignment requirement.
- `flush` = 1 on an edge:
  - aborts any fetch or LSB load (READ) back to IDLE with no `rdy`;
  - prevents acceptance of new loads and fetches that cycle.
  - Stores in progress are committed and always complete.
- `rdy_in` = 0: state, counters and registers hold. `mem_wr` is forced to 0 and requests are not sampled.

## Timing
- Reset values (`rst_in` = 0 at an edge): state IDLE; `if_rdy` = `mc_rdy` = 0; `if_data` = `mc_read_data` = 0; `mem_a` = 0; `mem_dout` = 0; `mem_wr` = 0.
- Cycle 0 is the acceptance edge.
  - Read: `rdy` in cycle n+2. Word load/fetch = cycle 6, byte = cycle 3.
  - Write: `rdy` in cycle n+1. Word store = cycle 5, byte = cycle 2.
- Back-to-back: the earliest next acceptance is the edge ending the cycle after DONE.
- All outputs are registered.
- Reset mid-transaction drops the transaction with no `rdy`, and `mem_wr` = 0 from the next cycle.

## Configuration
- `MC_IO_STALL_EN` defined:
  - a WRITE byte whose address has `[17:16]` = `IO_BASE_HI` is not issued while `io_buffer_full` = 1;
  - `mem_wr` stays 0 and the step counter holds until the input clears.
- Undefined: `io_buffer_full` is ignored and writes never stall.

## Structure
- The shared package holds `LSB_TYPE_WIDTH`, the size/unsigned/store field positions, the size codes and the FSM state encoding; the load/store buffer uses the same constants.
- One combinational sub-module, `load_extend`: inputs 32-bit raw data, size and unsigned flag; output 32-bit extended data.

## Test plan
- Fetch word at 0x1000, RAM bytes 13 05 00 00 -> `mem_a` 0x1000..0x1003 in cycles 1–4, `if_rdy` in cycle 6, `if_data` = 0x00000513.
- LB at 0x20 = 0x80 -> `mc_read_data` 0xFFFFFF80 in cycle 3; LBU at the same address -> 0x00000080.
- SW 0xDEADBEEF to 0x100 -> `mem_wr` = 1 with bytes EF BE AD DE at 0x100..0x103 in cycles 1–4, `mc_rdy` in cycle 5.
- `if_en` and `mc_en` both rise together -> LSB served first; fetch accepted after the LSB's DONE plus one cycle; each `rdy` pulses exactly once.
- Flush in cycle 2 of a fetch -> no `if_rdy` and IDLE next cycle. Flush during an SW -> all 4 bytes are written and `mc_rdy` fires.
- With `MC_IO_STALL_EN` defined: SB to 0x30000 while `io_buffer_full` = 1 for 3 cycles -> `mem_wr` stays 0 for those cycles, then one write, and `mc_rdy` follows in the next cycle.
